// File: rtl/core_defs.sv
// rtl/core_defs.sv - shared widths, ALU opcode encodings and forwarding helper for the 8-bit core
package core_defs;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int RW = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ADDC = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_SUBC = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_fn_e;

  // aluOp[3] swaps operand B for the immediate; IMM|PASS is the MOVI opcode
  localparam int         ALU_IMM_BIT = 3;
  localparam logic [3:0] ALU_MOVI    = 4'hF;

  function automatic logic [DW-1:0] fwd_pick(
    input logic [RW-1:0] idx,
    input logic          mem_wr,
    input logic [RW-1:0] mem_rd,
    input logic [DW-1:0] mem_data,
    input logic          wb_wr,
    input logic [RW-1:0] wb_rd,
    input logic [DW-1:0] wb_data,
    input logic [DW-1:0] reg_data
  );
    logic [DW-1:0] val;
    val = reg_data;
    if (idx != '0) begin
      if (mem_wr && (mem_rd == idx)) begin
        val = mem_data;
      end else if (wb_wr && (wb_rd == idx)) begin
        val = wb_data;
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EXE inputs, forwarding sources and EXE/MEM outputs of the execute stage
interface exe_stage_if;
  import core_defs::*;

  logic          regWr_IN;
  logic          memRd_IN;
  logic          memWr_IN;
  logic          cWr_IN;
  logic          zWr_IN;
  logic [3:0]    aluOp_IN;
  logic [RW-1:0] rd_IN;
  logic [RW-1:0] rs_IN;
  logic [RW-1:0] rt_IN;
  logic [DW-1:0] immConst_IN;
  logic [DW-1:0] regData1_IN;
  logic [DW-1:0] regData2_IN;
  logic [DW-1:0] brDisp_IN;
  logic [AW-1:0] pcPlus1_IN;

  logic          fwdMemRegWr_IN;
  logic          fwdWbRegWr_IN;
  logic [RW-1:0] fwdMemRd_IN;
  logic [RW-1:0] fwdWbRd_IN;
  logic [DW-1:0] fwdMemData_IN;
  logic [DW-1:0] fwdWbData_IN;

  logic          regWr_OUT;
  logic          memRd_OUT;
  logic          memWr_OUT;
  logic [RW-1:0] rd_OUT;
  logic [DW-1:0] aluRes_OUT;
  logic [DW-1:0] storeData_OUT;
  logic [AW-1:0] brTarget_OUT;
  logic          cFlag_OUT;
  logic          zFlag_OUT;

  modport master (
    output regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN, aluOp_IN,
    output rd_IN, rs_IN, rt_IN, immConst_IN, regData1_IN, regData2_IN,
    output brDisp_IN, pcPlus1_IN,
    output fwdMemRegWr_IN, fwdWbRegWr_IN, fwdMemRd_IN, fwdWbRd_IN,
    output fwdMemData_IN, fwdWbData_IN,
    input  regWr_OUT, memRd_OUT, memWr_OUT, rd_OUT, aluRes_OUT,
    input  storeData_OUT, brTarget_OUT, cFlag_OUT, zFlag_OUT
  );

  modport slave (
    input  regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN, aluOp_IN,
    input  rd_IN, rs_IN, rt_IN, immConst_IN, regData1_IN, regData2_IN,
    input  brDisp_IN, pcPlus1_IN,
    input  fwdMemRegWr_IN, fwdWbRegWr_IN, fwdMemRd_IN, fwdWbRd_IN,
    input  fwdMemData_IN, fwdWbData_IN,
    output regWr_OUT, memRd_OUT, memWr_OUT, rd_OUT, aluRes_OUT,
    output storeData_OUT, brTarget_OUT, cFlag_OUT, zFlag_OUT
  );

endinterface

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational 8-bit ALU; carry is bit 8 of a 9-bit sum
module alu8
  import core_defs::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  alu_fn_e       op,
  output logic [DW-1:0] res,
  output logic          cout,
  output logic          zero
);

  logic [DW:0] sum;

  // SUBC uses cin as "no borrow", so A+~B+cin gives carry=1 when no borrow occurs
  always_comb begin
    sum = '0;
    case (op)
      ALU_ADD:  sum = {1'b0, a} + {1'b0, b};
      ALU_ADDC: sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
      ALU_SUB:  sum = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
      ALU_SUBC: sum = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, cin};
      ALU_AND:  sum = {1'b0, a & b};
      ALU_OR:   sum = {1'b0, a | b};
      ALU_XOR:  sum = {1'b0, a ^ b};
      ALU_PASS: sum = {1'b0, b};
      default:  sum = '0;
    endcase
  end

  assign res  = sum[DW-1:0];
  assign cout = sum[DW];
  assign zero = (sum[DW-1:0] == '0);

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: operand forwarding, ALU, C/Z flags and the EXE/MEM register
module exe_stage
  import core_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  exe_stage_if.slave   bus
);

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b_fwd;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          alu_cout;
  logic          alu_zero;
  logic [AW-1:0] br_disp_ext;

  logic          regWr_q, regWr_d;
  logic          memRd_q, memRd_d;
  logic          memWr_q, memWr_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] aluRes_q, aluRes_d;
  logic [DW-1:0] storeData_q, storeData_d;
  logic [AW-1:0] brTarget_q, brTarget_d;
  logic          cFlag_q, cFlag_d;
  logic          zFlag_q, zFlag_d;

  assign op_a = fwd_pick(bus.rs_IN, bus.fwdMemRegWr_IN, bus.fwdMemRd_IN, bus.fwdMemData_IN,
                         bus.fwdWbRegWr_IN, bus.fwdWbRd_IN, bus.fwdWbData_IN, bus.regData1_IN);
  assign op_b_fwd = fwd_pick(bus.rt_IN, bus.fwdMemRegWr_IN, bus.fwdMemRd_IN, bus.fwdMemData_IN,
                             bus.fwdWbRegWr_IN, bus.fwdWbRd_IN, bus.fwdWbData_IN, bus.regData2_IN);
  assign op_b = bus.aluOp_IN[ALU_IMM_BIT] ? bus.immConst_IN : op_b_fwd;
  assign br_disp_ext = {{(AW-DW){bus.brDisp_IN[DW-1]}}, bus.brDisp_IN};

  alu8 u_alu (
    .a    (op_a),
    .b    (op_b),
    .cin  (cFlag_q),
    .op   (alu_fn_e'(bus.aluOp_IN[2:0])),
    .res  (alu_res),
    .cout (alu_cout),
    .zero (alu_zero)
  );

  // A flushed instruction still flows through but loses its side effects: no writes, no flag update
  always_comb begin
    regWr_d     = regWr_q;
    memRd_d     = memRd_q;
    memWr_d     = memWr_q;
    rd_d        = rd_q;
    aluRes_d    = aluRes_q;
    storeData_d = storeData_q;
    brTarget_d  = brTarget_q;
    cFlag_d     = cFlag_q;
    zFlag_d     = zFlag_q;
    if (!stall) begin
      regWr_d     = bus.regWr_IN && !flush;
      memRd_d     = bus.memRd_IN && !flush;
      memWr_d     = bus.memWr_IN && !flush;
      rd_d        = bus.rd_IN;
      aluRes_d    = alu_res;
      storeData_d = op_b_fwd;
      brTarget_d  = bus.pcPlus1_IN + br_disp_ext;
      if (!flush) begin
        if (bus.cWr_IN) cFlag_d = alu_cout;
        if (bus.zWr_IN) zFlag_d = alu_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regWr_q     <= 1'b0;
      memRd_q     <= 1'b0;
      memWr_q     <= 1'b0;
      rd_q        <= '0;
      aluRes_q    <= '0;
      storeData_q <= '0;
      brTarget_q  <= '0;
      cFlag_q     <= 1'b0;
      zFlag_q     <= 1'b0;
    end else begin
      regWr_q     <= regWr_d;
      memRd_q     <= memRd_d;
      memWr_q     <= memWr_d;
      rd_q        <= rd_d;
      aluRes_q    <= aluRes_d;
      storeData_q <= storeData_d;
      brTarget_q  <= brTarget_d;
      cFlag_q     <= cFlag_d;
      zFlag_q     <= zFlag_d;
    end
  end

  assign bus.regWr_OUT     = regWr_q;
  assign bus.memRd_OUT     = memRd_q;
  assign bus.memWr_OUT     = memWr_q;
  assign bus.rd_OUT        = rd_q;
  assign bus.aluRes_OUT    = aluRes_q;
  assign bus.storeData_OUT = storeData_q;
  assign bus.brTarget_OUT  = brTarget_q;
  assign bus.cFlag_OUT     = cFlag_q;
  assign bus.zFlag_OUT     = zFlag_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage with directed and randomized stimulus
module tb_exe_stage;
  import core_defs::*;

  logic clk = 1'b0;
  logic rst, stall, flush;
  always #5 clk = ~clk;

  exe_stage_if bus();

  exe_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    int regWr, memRd, memWr, rd, aluRes, storeData, brTarget, c, z;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int fwdv(input int idx, input int rf);
    if (idx != 0 && bus.fwdMemRegWr_IN && int'(bus.fwdMemRd_IN) == idx) return int'(bus.fwdMemData_IN);
    if (idx != 0 && bus.fwdWbRegWr_IN && int'(bus.fwdWbRd_IN) == idx) return int'(bus.fwdWbData_IN);
    return rf;
  endfunction

  // Reference: signed-integer arithmetic; carry on subtraction means "no borrow"
  function automatic void model_edge();
    int a, b, st, s, cy, t, disp;
    if (rst) begin
      m = '{default: 0};
      return;
    end
    if (stall) return;
    a  = fwdv(int'(bus.rs_IN), int'(bus.regData1_IN));
    st = fwdv(int'(bus.rt_IN), int'(bus.regData2_IN));
    b  = bus.aluOp_IN[3] ? int'(bus.immConst_IN) : st;
    cy = 0;
    case (int'(bus.aluOp_IN[2:0]))
      0: begin s = a + b;         cy = (s > 255) ? 1 : 0; end
      1: begin s = a + b + m.c;   cy = (s > 255) ? 1 : 0; end
      2: begin s = a - b;         cy = (a >= b) ? 1 : 0; end
      3: begin s = a - b - (1 - m.c); cy = (s >= 0) ? 1 : 0; end
      4: s = a & b;
      5: s = a | b;
      6: s = a ^ b;
      default: s = b;
    endcase
    s = s & 255;
    disp = int'(bus.brDisp_IN);
    if (disp >= 128) disp -= 256;
    t = int'(bus.pcPlus1_IN) + disp;
    m.regWr     = flush ? 0 : int'(bus.regWr_IN);
    m.memRd     = flush ? 0 : int'(bus.memRd_IN);
    m.memWr     = flush ? 0 : int'(bus.memWr_IN);
    m.rd        = int'(bus.rd_IN);
    m.aluRes    = s;
    m.storeData = st;
    m.brTarget  = ((t % 4096) + 4096) % 4096;
    if (!flush) begin
      if (bus.cWr_IN) m.c = cy;
      if (bus.zWr_IN) m.z = (s == 0) ? 1 : 0;
    end
  endfunction

  task automatic step();
    model_edge();
    q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 0; stall = 0; flush = 0;
    bus.regWr_IN = 0; bus.memRd_IN = 0; bus.memWr_IN = 0; bus.cWr_IN = 0; bus.zWr_IN = 0;
    bus.aluOp_IN = 0; bus.rd_IN = 0; bus.rs_IN = 0; bus.rt_IN = 0;
    bus.immConst_IN = 0; bus.regData1_IN = 0; bus.regData2_IN = 0;
    bus.brDisp_IN = 0; bus.pcPlus1_IN = 0;
    bus.fwdMemRegWr_IN = 0; bus.fwdWbRegWr_IN = 0; bus.fwdMemRd_IN = 0; bus.fwdWbRd_IN = 0;
    bus.fwdMemData_IN = 0; bus.fwdWbData_IN = 0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] imm,
                        input logic cwr, input logic zwr);
    bus.aluOp_IN = op; bus.rs_IN = rs; bus.rt_IN = rt;
    bus.regData1_IN = d1; bus.regData2_IN = d2; bus.immConst_IN = imm;
    bus.cWr_IN = cwr; bus.zWr_IN = zwr;
  endtask

  task automatic randomize_inputs();
    {bus.regWr_IN, bus.memRd_IN, bus.memWr_IN, bus.cWr_IN, bus.zWr_IN} = 5'($urandom);
    bus.aluOp_IN = 4'($urandom);
    bus.rd_IN = 3'($urandom); bus.rs_IN = 3'($urandom); bus.rt_IN = 3'($urandom);
    bus.immConst_IN = 8'($urandom); bus.regData1_IN = 8'($urandom); bus.regData2_IN = 8'($urandom);
    bus.brDisp_IN = 8'($urandom); bus.pcPlus1_IN = 12'($urandom);
    bus.fwdMemRegWr_IN = 1'($urandom); bus.fwdWbRegWr_IN = 1'($urandom);
    bus.fwdMemRd_IN = 3'($urandom); bus.fwdWbRd_IN = 3'($urandom);
    bus.fwdMemData_IN = 8'($urandom); bus.fwdWbData_IN = 8'($urandom);
  endtask

  // Monitor: every edge presents one EXE/MEM word, compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_regWr", int'(bus.regWr_OUT), e.regWr);
        chk("sb_memRd", int'(bus.memRd_OUT), e.memRd);
        chk("sb_memWr", int'(bus.memWr_OUT), e.memWr);
        chk("sb_rd", int'(bus.rd_OUT), e.rd);
        chk("sb_aluRes", int'(bus.aluRes_OUT), e.aluRes);
        chk("sb_storeData", int'(bus.storeData_OUT), e.storeData);
        chk("sb_brTarget", int'(bus.brTarget_OUT), e.brTarget);
        chk("sb_cFlag", int'(bus.cFlag_OUT), e.c);
        chk("sb_zFlag", int'(bus.zFlag_OUT), e.z);
      end
    end
  end

  initial begin
    int frz_res, frz_c, frz_z, frz_br, wait_cyc;
    clr();
    randomize_inputs();
    bus.regWr_IN = 1; bus.memWr_IN = 1; bus.cWr_IN = 1; bus.zWr_IN = 1;
    rst = 1;
    step();
    chk("rst_aluRes", int'(bus.aluRes_OUT), 0);
    chk("rst_brTarget", int'(bus.brTarget_OUT), 0);
    chk("rst_regWr", int'(bus.regWr_OUT), 0);
    chk("rst_memWr", int'(bus.memWr_OUT), 0);
    chk("rst_flags", int'({bus.cFlag_OUT, bus.zFlag_OUT}), 0);

    clr();
    set_op({1'b0, ALU_ADD}, 3'd1, 3'd2, 8'hF0, 8'h20, 8'h00, 1, 1);
    step();
    chk("add_res", int'(bus.aluRes_OUT), 'h10);
    chk("add_c", int'(bus.cFlag_OUT), 1);
    chk("add_z", int'(bus.zFlag_OUT), 0);
    set_op({1'b0, ALU_ADDC}, 3'd1, 3'd2, 8'h01, 8'h01, 8'h00, 1, 1);
    step();
    chk("addc_res", int'(bus.aluRes_OUT), 'h03);

    set_op({1'b0, ALU_PASS}, 3'd3, 3'd3, 8'h11, 8'h11, 8'h00, 0, 0);
    bus.fwdMemRegWr_IN = 1; bus.fwdMemRd_IN = 3; bus.fwdMemData_IN = 8'h22;
    bus.fwdWbRegWr_IN = 1; bus.fwdWbRd_IN = 3; bus.fwdWbData_IN = 8'h33;
    step();
    chk("fwd_mem", int'(bus.aluRes_OUT), 'h22);
    bus.fwdMemRegWr_IN = 0;
    step();
    chk("fwd_wb", int'(bus.aluRes_OUT), 'h33);
    chk("fwd_wb_store", int'(bus.storeData_OUT), 'h33);
    set_op({1'b0, ALU_PASS}, 3'd0, 3'd0, 8'h44, 8'h44, 8'h00, 0, 0);
    bus.fwdMemRegWr_IN = 1; bus.fwdMemRd_IN = 0; bus.fwdWbRd_IN = 0;
    step();
    chk("fwd_r0", int'(bus.aluRes_OUT), 'h44);

    clr();
    set_op({1'b1, ALU_SUB}, 3'd1, 3'd2, 8'h05, 8'h77, 8'h05, 1, 1);
    step();
    chk("subi_res", int'(bus.aluRes_OUT), 0);
    chk("subi_z", int'(bus.zFlag_OUT), 1);
    chk("subi_c", int'(bus.cFlag_OUT), 1);
    chk("subi_store", int'(bus.storeData_OUT), 'h77);
    bus.regData1_IN = 8'h04;
    step();
    chk("subi_borrow_res", int'(bus.aluRes_OUT), 'hFF);
    chk("subi_borrow_c", int'(bus.cFlag_OUT), 0);
    set_op(ALU_MOVI, 3'd1, 3'd2, 8'h00, 8'h00, 8'h5A, 0, 0);
    step();
    chk("movi_res", int'(bus.aluRes_OUT), 'h5A);

    frz_res = int'(bus.aluRes_OUT); frz_c = int'(bus.cFlag_OUT);
    frz_z = int'(bus.zFlag_OUT); frz_br = int'(bus.brTarget_OUT);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1;
      flush = (i == 1);
      step();
    end
    chk("stall_res", int'(bus.aluRes_OUT), frz_res);
    chk("stall_br", int'(bus.brTarget_OUT), frz_br);
    chk("stall_flags", int'({bus.cFlag_OUT, bus.zFlag_OUT}), (frz_c << 1) | frz_z);

    clr();
    set_op({1'b0, ALU_ADD}, 3'd1, 3'd2, 8'hF0, 8'h20, 8'h00, 1, 1);
    bus.memWr_IN = 1; bus.regWr_IN = 1; flush = 1;
    step();
    chk("flush_memWr", int'(bus.memWr_OUT), 0);
    chk("flush_regWr", int'(bus.regWr_OUT), 0);
    chk("flush_c", int'(bus.cFlag_OUT), frz_c);

    clr();
    bus.pcPlus1_IN = 12'h005; bus.brDisp_IN = 8'hFA;
    step();
    chk("br_back", int'(bus.brTarget_OUT), 'hFFF);
    bus.pcPlus1_IN = 12'hFFF; bus.brDisp_IN = 8'h01;
    step();
    chk("br_wrap", int'(bus.brTarget_OUT), 'h000);

    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      rst   = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 15);
      step();
    end

    clr();
    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      #3;
      wait_cyc++;
    end
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage that consumes the ID/EXE bundle and drives the EXE/MEM boundary for the 8-bit pipelined core (12-bit PC, 8 registers, C/Z flags).
- Resolves operand forwarding from EXE/MEM and MEM/WB, runs the 8-bit ALU, and owns the architectural carry and zero flag registers.
- Registers its results, plus the computed branch target, into the EXE/MEM stage.

Parameters:
- DW, 8, datapath width
- AW, 12, PC/address width
- RW, 3, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold all state (hazard unit)
- flush  in  1  insert bubble into EXE/MEM
- regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN  in  1 each  control from ID/EXE
- aluOp_IN  in  4  ALU operation
- rd_IN, rs_IN, rt_IN  in  3 each  register indices
- immConst_IN, regData1_IN, regData2_IN, brDisp_IN  in  8 each  immediate, rs data, rt data, branch displacement
- pcPlus1_IN  in  12  PC+1 of the instruction
- fwdMemRegWr_IN, fwdWbRegWr_IN  in  1 each  writer valid in EXE/MEM and MEM/WB
- fwdMemRd_IN, fwdWbRd_IN  in  3 each  destinations of those writers
- fwdMemData_IN, fwdWbData_IN  in  8 each  their result values
- regWr_OUT, memRd_OUT, memWr_OUT  out  1 each  registered control to EXE/MEM
- rd_OUT  out  3  registered destination
- aluRes_OUT, storeData_OUT  out  8 each  registered ALU result, forwarded rt value
- brTarget_OUT  out  12  registered pcPlus1 + sign-extended brDisp
- cFlag_OUT, zFlag_OUT  out  1 each  flag registers

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst: at the posedge with rst=1, all _OUT registers and both flags become 0. rst has priority over stall and flush.
- Forwarding (combinational, per operand; rs→A, rt→B):
  - Use fwdMem when fwdMemRegWr_IN=1, fwdMemRd_IN==index and index!=0.
  - Otherwise use fwdWb under the same conditions.
  - Otherwise use regData. EXE/MEM has priority over MEM/WB.
  - R0 is hardwired zero and is never forwarded.
  - Load-use hazards are the hazard unit's job; this block does not detect them.
- ALU operand B: aluOp_IN[3]=1 selects immConst_IN; otherwise forwarded rt.
- ALU function, aluOp_IN[2:0], 9-bit arithmetic, carry = bit 8:
  - 0 ADD: A+B
  - 1 ADDC: A+B+C
  - 2 SUB: A+~B+1
  - 3 SUBC: A+~B+C (C=1 means no borrow)
  - 4 AND, 5 OR, 6 XOR: carry 0
  - 7 PASS: result = B
  - Opcode 15 is MOVI.
- Flags: zero = (result==0). At the posedge, when !rst && !stall && !flush:
  - cWr_IN=1 loads cFlag.
  - zWr_IN=1 loads zFlag.
  - Otherwise each flag holds.
  - Back-to-back ADD→ADDC works because the flags are written at end of EXE and read in the next EXE cycle.
- Stage register, latency 1:
  - Normal cycle: capture all outputs.
  - stall=1 (and no rst): hold every output and both flags, even if flush=1.
  - flush=1 (stall=0): regWr_OUT, memRd_OUT and memWr_OUT = 0, flags unchanged, other outputs don't-care (capture normally).
- storeData_OUT = forwarded rt value, never immConst.
- brTarget: 12-bit wrap-around add, pcPlus1 + {{4{brDisp[7]}},brDisp}. 0xFFF+1 wraps to 0x000.

Decomposition:
- Shared package/header `core_defs`:
  - aluOp encodings: ALU_ADD..ALU_PASS and the IMM bit, with opcode 15 named ALU_MOVI.
  - DW/AW/RW constants.
- One sub-module `alu8` (combinational: A, B, cin, op → res, cout, zero).
- Forwarding muxes, flags and the stage register stay in exe_stage.

Test Plan:
- Reset: drive inputs nonzero, rst=1 for one edge → every _OUT = 0, cFlag = zFlag = 0.
- ADD with flags: A=0xF0, B=0x20, op ADD, cWr=zWr=1 → aluRes_OUT=0x10, cFlag=1, zFlag=0. Next cycle ADDC 0x01+0x01 → 0x03.
- Forwarding priority: rs=3, regData1=0x11, fwdMem(rd=3, data 0x22), fwdWb(rd=3, data 0x33), op PASS with rt=rs → 0x22. Drop the mem valid → 0x33. rs=0 with both valid → regData value used.
- Immediate/SUB: op SUBI, A=0x05, imm=0x05 → aluRes=0x00, zFlag=1, cFlag=1. Op SUBI with A=0x04 → 0xFF, cFlag=0.
- Stall/flush: stall=1 for 3 cycles with changing inputs → outputs and flags frozen. flush=1 with memWr_IN=1, cWr_IN=1 → memWr_OUT=0, regWr_OUT=0, cFlag unchanged.
- Branch target: pcPlus1=0x005, brDisp=0xFA → brTarget_OUT=0xFFF. pcPlus1=0xFFF, brDisp=0x01 → 0x000.
